// File: rtl/seq_check_pkg.sv
// Shared types and defaults for the 16-bit sequence checker.
// Holds the FSM state encoding exported on state_dbg and the default geometry.
package seq_check_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_LOCK_N = 4;
    localparam int DEF_ERR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Bits needed for a run counter that must be able to hold the value n.
    function automatic int run_bits(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_checker_16bit_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// An increment in the same cycle as clr restarts the count at one.
module sat_counter
    import seq_check_pkg::*;
#(
    parameter int W = DEF_ERR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;
    logic [W-1:0] q_nxt_s;
    logic         at_max_s;

    // next count: increment beats clear, and the count sticks at all-ones
    always_comb begin
        q_nxt_s  = q_r;
        at_max_s = (q_r == {W{1'b1}});
        if (inc) begin
            if (clr) begin
                q_nxt_s = W'(1);
            end else if (at_max_s) begin
                q_nxt_s = q_r;
            end else begin
                q_nxt_s = q_r + W'(1);
            end
        end else if (clr) begin
            q_nxt_s = {W{1'b0}};
        end else begin
            q_nxt_s = q_r;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {W{1'b0}};
        end else begin
            q_r <= q_nxt_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/seq_checker_16bit.sv
// Receive-side checker for an enable-gated up-counter: locks onto the incoming
// sequence and counts +1 violations while locked.
module seq_checker_16bit
    import seq_check_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOCK_N = DEF_LOCK_N,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] last_exp,
    output logic [1:0]       state_dbg
);

    localparam int GR_W = run_bits(LOCK_N);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [GR_W-1:0]   good_run_r;
    logic [GR_W-1:0]   good_run_nxt_s;
    logic [GR_W-1:0]   run_inc_s;
    logic              lock_hit_s;
    logic [WIDTH-1:0]  exp_r;
    logic [WIDTH-1:0]  last_exp_r;
    logic              err_sticky_r;
    logic              locked_r;
    logic              match_s;
    logic              count_err_s;
    logic              locked_nxt_s;

    assign match_s    = (cnt_in == exp_r);
    assign run_inc_s  = good_run_r + GR_W'(1);
    assign lock_hit_s = (run_inc_s == GR_W'(LOCK_N));

    // state and match-run registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            good_run_r <= {GR_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            good_run_r <= good_run_nxt_s;
        end
    end

    // next-state logic; only sample cycles move the FSM
    always_comb begin
        state_nxt_s    = state_r;
        good_run_nxt_s = good_run_r;
        if (en) begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s    = ST_SYNC;
                    good_run_nxt_s = {GR_W{1'b0}};
                end
                ST_SYNC: begin
                    if (match_s && lock_hit_s) begin
                        state_nxt_s    = ST_LOCKED;
                        good_run_nxt_s = {GR_W{1'b0}};
                    end else if (match_s) begin
                        state_nxt_s    = ST_SYNC;
                        good_run_nxt_s = run_inc_s;
                    end else begin
                        state_nxt_s    = ST_SYNC;
                        good_run_nxt_s = {GR_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        state_nxt_s    = ST_LOCKED;
                        good_run_nxt_s = good_run_r;
                    end else begin
                        state_nxt_s    = ST_SYNC;
                        good_run_nxt_s = {GR_W{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    good_run_nxt_s = {GR_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s    = state_r;
            good_run_nxt_s = good_run_r;
        end
    end

    // output decode: counted errors only arise from a LOCKED-state sample
    always_comb begin
        count_err_s  = 1'b0;
        locked_nxt_s = (state_nxt_s == ST_LOCKED);
        if (en && (state_r == ST_LOCKED) && !match_s) begin
            count_err_s = 1'b1;
        end else begin
            count_err_s = 1'b0;
        end
    end

    // expected next value, wrapping naturally at WIDTH bits
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_r <= {WIDTH{1'b0}};
        end else if (en) begin
            exp_r <= cnt_in + WIDTH'(1);
        end else begin
            exp_r <= exp_r;
        end
    end

    // error capture; a counted mismatch outranks a coincident clr
    always_ff @(posedge clk) begin
        if (rst) begin
            last_exp_r   <= {WIDTH{1'b0}};
            err_sticky_r <= 1'b0;
        end else if (count_err_s) begin
            last_exp_r   <= exp_r;
            err_sticky_r <= 1'b1;
        end else if (clr) begin
            last_exp_r   <= last_exp_r;
            err_sticky_r <= 1'b0;
        end else begin
            last_exp_r   <= last_exp_r;
            err_sticky_r <= err_sticky_r;
        end
    end

    // locked is a registered copy of the LOCKED decode
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_r <= 1'b0;
        end else begin
            locked_r <= locked_nxt_s;
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .inc(count_err_s),
        .q  (err_cnt)
    );

    assign locked     = locked_r;
    assign err_sticky = err_sticky_r;
    assign last_exp   = last_exp_r;
    assign state_dbg  = state_r;

endmodule

// File: doc/seq_checker_16bit.md
Name: seq_checker_16bit

Overview:
Receive-side companion to the 16-bit enable-gated up-counter user design, and the reader for that counter's writer.
- Samples a counter value presented on fabric I/O whenever the shared enable strobe is high.
- Locks onto the sequence and checks that each sample is the previous sample plus one, modulo 2^WIDTH.
- Reports lock status, a sticky error flag, a saturating error count and the last expected value, for on-board debug of the fabric under test.

Parameters:
WIDTH, 16, width of the checked counter value
LOCK_N, 4, consecutive matching samples required to enter LOCKED (≥1)
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  fabric clock; all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  sample strobe, same signal that enables the writer counter
cnt_in  in  WIDTH  counter value under check
clr  in  1  clears err_cnt and err_sticky only
locked  out  1  high while state is LOCKED
err_sticky  out  1  set on any LOCKED-state mismatch; held until clr or rst
err_cnt  out  ERR_W  saturating count of LOCKED-state mismatches
last_exp  out  WIDTH  expected value at the most recent counted mismatch
state_dbg  out  2  encoded FSM state: IDLE=0, SYNC=1, LOCKED=2

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE; exp, good_run, err_cnt and last_exp all 0.
  - err_sticky=0, locked=0.
  - rst overrides every other input in the same cycle, including mid-LOCKED.
- Sampling:
  - A sample is any cycle with en=1 and rst=0. Cycles with en=0 change nothing; gaps of any length are legal.
  - The writer increments exactly once between consecutive en cycles, so consecutive samples must differ by +1.
- Expected value: exp <= cnt_in + 1 on every sample in every state, truncated to WIDTH bits. 0xFFFF -> 0x0000 is a match.
- IDLE:
  - On a sample: load exp, set good_run=0, go to SYNC.
  - No error is ever counted in IDLE.
- SYNC:
  - On a sample with cnt_in==exp: good_run++. If good_run reaches LOCK_N, go to LOCKED and clear good_run.
  - On a sample with cnt_in!=exp: good_run=0 and stay in SYNC. This mismatch is NOT counted as an error.
- LOCKED, sample with cnt_in==exp: stay in LOCKED.
- LOCKED, sample with cnt_in!=exp (this includes repeats and writer resets to 0):
  - last_exp <= exp;
  - err_sticky <= 1;
  - err_cnt <= err_cnt+1, saturating at 2^ERR_W-1;
  - good_run <= 0;
  - next state SYNC.
- clr:
  - clr=1 with no counted mismatch in the same cycle: err_cnt=0 and err_sticky=0.
  - clr and a counted mismatch in the same cycle: the mismatch wins, giving err_cnt=1 and err_sticky=1.
  - clr does not affect state, exp or last_exp.
- Latency:
  - All outputs are registered and reflect a sample at the posedge ending the sample cycle.
  - locked is a registered decode of state; it is not combinational from inputs.
- Width rules:
  - good_run is sized to hold LOCK_N.
  - All compares are full WIDTH bits, unsigned.

Decomposition:
- Shared package seq_check_pkg holds:
  - the state enum (IDLE, SYNC, LOCKED) and its 2-bit encoding for state_dbg;
  - default constants for WIDTH, LOCK_N and ERR_W.
- One sub-module, sat_counter:
  - parameter W; ports clk, rst, clr, inc; output q;
  - saturating increment; inc has priority over clr (inc with clr gives q=1).
  - Used for err_cnt.
- The FSM, exp register and last_exp capture stay in seq_checker_16bit.

Test Plan:
- Lock-in: after rst, en=1 with cnt_in 0,1,2,3,4 (LOCK_N=4) -> state_dbg goes IDLE->SYNC after sample 0, and locked=1 after the edge ending sample 4; err_cnt=0 and err_sticky=0 throughout.
- Wrap and gaps: while locked, feed 0xFFFE, en=0 for 3 cycles holding 0xFFFE, then 0xFFFF, 0x0000, 0x0001 -> locked stays 1 and err_cnt=0.
- Skip error and relock: locked with exp=0x0010, cnt_in=0x0012 -> the next cycle shows err_cnt=1, err_sticky=1, last_exp=0x0010, locked=0, state_dbg=SYNC. Then 0x0013..0x0016 -> locked=1 again, and err_sticky is still 1.
- Saturation and clr priority (ERR_W=8): alternate relock/mismatch until 300 counted errors -> err_cnt=255. Then clr=1 alone -> err_cnt=0, err_sticky=0. Then clr=1 coincident with a LOCKED mismatch -> err_cnt=1, err_sticky=1.
- SYNC mismatches not counted: after rst, samples 5, 9, 9, 20 -> state stays SYNC, err_cnt=0, err_sticky=0.
- Mid-operation reset: locked with err_cnt=3, assert rst for 1 cycle with en=1 -> the next cycle shows state_dbg=IDLE and all outputs 0; the following sample enters SYNC.
